// File: rtl/cbm2_sched_pkg.sv
// Shared constants for the CBM-II system-cycle sequencer: bus slot identifiers
// and the width helper used to size the slot/subcycle counters.
package cbm2_sched_pkg;

    typedef enum logic [2:0] {
        SLOT_EXT = 3'd0,
        SLOT_CPU = 3'd1,
        SLOT_COP = 3'd2,
        SLOT_VID = 3'd3,
        SLOT_NOP = 3'd4
    } slot_id_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int sched_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cbm2_sched_pixdiv.sv
// VIC pixel-enable divider: one pulse every PIX_DIV clk_sys cycles, restarted
// at every frame boundary and held cleared while the system is paused.
module cbm2_sched_pixdiv
    import cbm2_sched_pkg::*;
#(
    parameter int PIX_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic enable,
    input  logic frame_end,
    output logic pixel_en
);

    localparam int PW = sched_width(PIX_DIV);
    localparam logic [PW-1:0] PIX_MAX = PW'(PIX_DIV - 1);

    logic [PW-1:0] pix_cnt_r;

    // Divider count with synchronous clear.
    always_ff @(posedge clk_sys) begin
        if (reset || !enable || frame_end) begin
            pix_cnt_r <= '0;
        end else if (pix_cnt_r == PIX_MAX) begin
            pix_cnt_r <= '0;
        end else begin
            pix_cnt_r <= pix_cnt_r + PW'(1);
        end
    end

    assign pixel_en = enable && (pix_cnt_r == PIX_MAX);

endmodule

// File: rtl/cbm2_cycle_sched.sv
// CBM-II system-cycle sequencer: slot/subcycle frame, refresh and pause windows,
// frame-aligned reset and pixel enable. Define CBM2_SCHED_DMA_EN for DMA slot stealing.
module cbm2_cycle_sched
    import cbm2_sched_pkg::*;
#(
    parameter  int SLOTS    = 5,
    parameter  int SUB      = 4,
    parameter  int RFSH_DIV = 8,
    parameter  int PIX_DIV  = 4,
    parameter  int DMA_SLOT = 4,
    localparam int SW       = sched_width(SLOTS + 1),
    localparam int SUBW     = sched_width(SUB)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             reset_req,
    input  logic             pause,
    input  logic [SW-1:0]    active_slots,
    input  logic [1:0]       tail_len,
    input  logic [SLOTS-1:0] fast_mask,
    input  logic             dma_req,
    output logic [SW-1:0]    slot,
    output logic [SUBW-1:0]  sub,
    output logic             slot_valid,
    output logic             slot_first,
    output logic             slot_last,
    output logic             frame_end,
    output logic             phase,
    output logic             refresh,
    output logic             sys_enable,
    output logic             pause_out,
    output logic             sys_reset,
    output logic             io_cycle,
    output logic             pixel_en,
    output logic             dma_gnt
);

    localparam int RW = sched_width(RFSH_DIV);
    localparam logic [SUBW-1:0] SUB_MAX  = SUBW'(SUB - 1);
    localparam logic [SW-1:0]   SLOTS_W  = SW'(SLOTS);
    localparam logic [SW-1:0]   DMA_IDX  = SW'(DMA_SLOT);
    localparam logic [RW-1:0]   RFSH_MAX = RW'(RFSH_DIV - 1);

    logic [SW-1:0]   slot_cnt_r;
    logic [SUBW-1:0] sub_cnt_r;
    logic [1:0]      tail_cnt_r;
    logic            in_tail_r;
    logic [SW-1:0]   act_sh_r;
    logic [1:0]      tail_sh_r;
    logic [RW-1:0]   rfsh_cnt_r;
    logic            phase_r;
    logic            sys_enable_r;
    logic            sys_reset_r;
    logic            refresh_r;
    logic            run_r;

    logic [SW-1:0]   act_in_s;
    logic            last_slot_s;
    logic            slot_end_s;
    logic            frame_end_s;
    logic [SW-1:0]   nxt_slot_s;
    logic [SUBW-1:0] nxt_sub_s;
    logic [1:0]      nxt_tail_cnt_s;
    logic            nxt_in_tail_s;
    logic [SW-1:0]   slot_out_s;
    logic            base_valid_s;
    logic            dma_gnt_s;

    assign act_in_s    = ((active_slots == '0) || (active_slots > SLOTS_W)) ? SLOTS_W : active_slots;
    assign last_slot_s = (slot_cnt_r == (act_sh_r - SW'(1)));
    assign slot_end_s  = !in_tail_r && (sub_cnt_r == SUB_MAX);
    assign frame_end_s = (slot_end_s && last_slot_s && (tail_sh_r == 2'd0)) ||
                         (in_tail_r && (tail_cnt_r == (tail_sh_r - 2'd1)));

    // Next position in the frame: subcycles, then slots, then idle tail.
    always_comb begin
        nxt_slot_s     = slot_cnt_r;
        nxt_sub_s      = sub_cnt_r;
        nxt_tail_cnt_s = tail_cnt_r;
        nxt_in_tail_s  = in_tail_r;
        if (frame_end_s) begin
            nxt_slot_s     = '0;
            nxt_sub_s      = '0;
            nxt_tail_cnt_s = 2'd0;
            nxt_in_tail_s  = 1'b0;
        end else if (in_tail_r) begin
            nxt_tail_cnt_s = tail_cnt_r + 2'd1;
        end else if (sub_cnt_r == SUB_MAX) begin
            nxt_sub_s = '0;
            if (last_slot_s) begin
                nxt_in_tail_s = 1'b1;
            end else begin
                nxt_slot_s = slot_cnt_r + SW'(1);
            end
        end else begin
            nxt_sub_s = sub_cnt_r + SUBW'(1);
        end
    end

    // Frame counters plus everything that only changes at a frame boundary.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            slot_cnt_r   <= '0;
            sub_cnt_r    <= '0;
            tail_cnt_r   <= 2'd0;
            in_tail_r    <= 1'b0;
            act_sh_r     <= act_in_s;
            tail_sh_r    <= tail_len;
            rfsh_cnt_r   <= '0;
            phase_r      <= 1'b0;
            sys_enable_r <= 1'b0;
            sys_reset_r  <= 1'b1;
            refresh_r    <= 1'b0;
            run_r        <= 1'b0;
        end else begin
            run_r      <= 1'b1;
            slot_cnt_r <= nxt_slot_s;
            sub_cnt_r  <= nxt_sub_s;
            tail_cnt_r <= nxt_tail_cnt_s;
            in_tail_r  <= nxt_in_tail_s;
            refresh_r  <= frame_end_s && (rfsh_cnt_r == '0);
            if (frame_end_s) begin
                act_sh_r    <= act_in_s;
                tail_sh_r   <= tail_len;
                phase_r     <= ~phase_r;
                sys_reset_r <= reset_req;
                rfsh_cnt_r  <= (rfsh_cnt_r == RFSH_MAX) ? '0 : rfsh_cnt_r + RW'(1);
                // Pause is only honoured at the start of a refresh window.
                if (rfsh_cnt_r == '0) begin
                    sys_enable_r <= ~pause;
                end
            end
        end
    end

    assign slot_out_s   = (sys_enable_r && !in_tail_r) ? slot_cnt_r : '0;
    assign base_valid_s = sys_enable_r && !in_tail_r && (fast_mask[slot_cnt_r] || phase_r);

`ifdef CBM2_SCHED_DMA_EN
    logic dma_own_r;
    logic dma_sample_s;

    assign dma_sample_s = !nxt_in_tail_s && (nxt_slot_s == DMA_IDX) && (nxt_sub_s == '0);

    // Ownership is decided once, just before the DMA slot begins, and held for the slot.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dma_own_r <= 1'b0;
        end else if (dma_sample_s) begin
            dma_own_r <= dma_req && sys_enable_r;
        end else if (slot_end_s && (slot_cnt_r == DMA_IDX)) begin
            dma_own_r <= 1'b0;
        end
    end

    assign dma_gnt_s = dma_own_r && base_valid_s && (slot_cnt_r == DMA_IDX);
`else
    assign dma_gnt_s = dma_req & 1'b0;
`endif

    cbm2_sched_pixdiv #(
        .PIX_DIV (PIX_DIV)
    ) u_pixdiv (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (sys_enable_r),
        .frame_end (frame_end_s),
        .pixel_en  (pixel_en)
    );

    assign slot       = slot_out_s;
    assign sub        = sys_enable_r ? sub_cnt_r : '0;
    assign slot_valid = base_valid_s && !dma_gnt_s;
    assign slot_first = slot_valid && (sub_cnt_r == '0);
    assign slot_last  = slot_valid && (sub_cnt_r == SUB_MAX);
    assign frame_end  = frame_end_s;
    assign phase      = phase_r;
    assign refresh    = refresh_r;
    assign sys_enable = sys_enable_r;
    assign pause_out  = ~sys_enable_r;
    assign sys_reset  = sys_reset_r;
    assign io_cycle   = run_r && !in_tail_r && (slot_out_s == SW'(SLOT_EXT)) && (rfsh_cnt_r != RW'(1));
    assign dma_gnt    = dma_gnt_s;

endmodule

// File: tb/tb_cbm2_cycle_sched.sv
// Self-checking bench for cbm2_cycle_sched: directed frame/pause/reset scenarios
// followed by randomized inputs, all checked against a frame-position model.
module tb_cbm2_cycle_sched;

    localparam int SLOTS    = 5;
    localparam int SUB      = 4;
    localparam int RFSH_DIV = 8;
    localparam int PIX_DIV  = 4;
    localparam int DMA_SLOT = 4;
    localparam int SW       = 3;
    localparam int SUBW     = 2;

    logic             clk_sys = 1'b0;
    logic             reset, reset_req, pause, dma_req;
    logic [SW-1:0]    active_slots;
    logic [1:0]       tail_len;
    logic [SLOTS-1:0] fast_mask;
    logic [SW-1:0]    slot;
    logic [SUBW-1:0]  sub;
    logic slot_valid, slot_first, slot_last, frame_end, phase, refresh;
    logic sys_enable, pause_out, sys_reset, io_cycle, pixel_en, dma_gnt;

    int checks   = 0;
    int failures = 0;

    // Model: position within the frame and completed-frame count.
    int m_pos, m_act, m_tail, m_frames, m_cyc;
    bit m_en, m_ref, m_srst, m_run, m_own;

    always #5 clk_sys = ~clk_sys;

    cbm2_cycle_sched #(
        .SLOTS(SLOTS), .SUB(SUB), .RFSH_DIV(RFSH_DIV), .PIX_DIV(PIX_DIV), .DMA_SLOT(DMA_SLOT)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .reset_req(reset_req), .pause(pause),
        .active_slots(active_slots), .tail_len(tail_len), .fast_mask(fast_mask),
        .dma_req(dma_req), .slot(slot), .sub(sub), .slot_valid(slot_valid),
        .slot_first(slot_first), .slot_last(slot_last), .frame_end(frame_end),
        .phase(phase), .refresh(refresh), .sys_enable(sys_enable), .pause_out(pause_out),
        .sys_reset(sys_reset), .io_cycle(io_cycle), .pixel_en(pixel_en), .dma_gnt(dma_gnt)
    );

    function automatic int clampv(input int a);
        return (a == 0 || a > SLOTS) ? SLOTS : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic model_edge();
        int len;
        int rf;
        bit fe;
        bit old_en;
        len    = m_act * SUB + m_tail;
        fe     = (m_pos == len - 1);
        rf     = m_frames % RFSH_DIV;
        old_en = m_en;
        if (reset) begin
            m_pos = 0; m_frames = 0; m_cyc = 0;
            m_act = clampv(int'(active_slots)); m_tail = int'(tail_len);
            m_en = 0; m_ref = 0; m_srst = 1; m_run = 0; m_own = 0;
        end else begin
            m_run = 1;
            m_cyc++;
            m_ref = fe && (rf == 0);
            if (fe) begin
                m_frames++;
                m_srst = reset_req;
                if (rf == 0) m_en = !pause;
                m_pos  = 0;
                m_act  = clampv(int'(active_slots));
                m_tail = int'(tail_len);
            end else begin
                m_pos++;
            end
`ifdef CBM2_SCHED_DMA_EN
            if (m_pos == DMA_SLOT * SUB && DMA_SLOT < m_act) m_own = old_en && dma_req;
`endif
        end
    endtask

    task automatic compare_all();
        int len, s, u, rf, slot_e, sub_e;
        bit in_slot, ph, fe, base, gnt, valid, io, pix;
        len     = m_act * SUB;
        in_slot = (m_pos < len);
        s       = m_pos / SUB;
        u       = m_pos % SUB;
        ph      = (m_frames % 2) == 1;
        rf      = m_frames % RFSH_DIV;
        fe      = (m_pos == len + m_tail - 1);
        base    = in_slot ? (m_en && (fast_mask[s] === 1'b1 || ph)) : 1'b0;
`ifdef CBM2_SCHED_DMA_EN
        gnt     = m_own && base && (s == DMA_SLOT);
`else
        gnt     = 1'b0;
`endif
        valid   = base && !gnt;
        slot_e  = (m_en && in_slot) ? s : 0;
        sub_e   = (m_en && in_slot) ? u : 0;
        io      = m_run && in_slot && (!m_en || s == 0) && (rf != 1);
        pix     = m_en && ((m_pos % PIX_DIV) == PIX_DIV - 1);
        chk("slot",       32'(slot),       32'(slot_e));
        chk("sub",        32'(sub),        32'(sub_e));
        chk("slot_valid", 32'(slot_valid), 32'(valid));
        chk("slot_first", 32'(slot_first), 32'(valid && u == 0));
        chk("slot_last",  32'(slot_last),  32'(valid && u == SUB - 1));
        chk("frame_end",  32'(frame_end),  32'(fe));
        chk("phase",      32'(phase),      32'(ph));
        chk("refresh",    32'(refresh),    32'(m_ref));
        chk("sys_enable", 32'(sys_enable), 32'(m_en));
        chk("pause_out",  32'(pause_out),  32'(!m_en));
        chk("sys_reset",  32'(sys_reset),  32'(m_srst));
        chk("io_cycle",   32'(io_cycle),   32'(io));
        chk("pixel_en",   32'(pixel_en),   32'(pix));
        chk("dma_gnt",    32'(dma_gnt),    32'(gnt));
    endtask

    task automatic tick();
        #1;
        compare_all();
        @(posedge clk_sys);
        model_edge();
        @(negedge clk_sys);
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0; pause = 1'b0; dma_req = 1'b0;
        active_slots = 3'd4; tail_len = 2'd0; fast_mask = 5'b11101;
        @(posedge clk_sys);
        model_edge();
        @(negedge clk_sys);
        repeat (2) begin
            #1;
            chk("rst_pause_out", 32'(pause_out), 32'd1);
            chk("rst_sys_reset", 32'(sys_reset), 32'd1);
            chk("rst_slot",      32'(slot),      32'd0);
            chk("rst_io_cycle",  32'(io_cycle),  32'd0);
            tick();
        end
        reset = 1'b0;

        // act=4, tail=0, slot1 half-rate; pause held from cycle 20 to 149.
        while (m_cyc < 171) begin
            pause = (m_cyc >= 20 && m_cyc < 150);
            #1;
            case (m_cyc)
                15: begin
                    chk("fe_at_15", 32'(frame_end), 32'd1);
                    chk("en_at_15", 32'(sys_enable), 32'd0);
                end
                16: begin
                    chk("refresh_at_16", 32'(refresh), 32'd1);
                    chk("en_at_16", 32'(sys_enable), 32'd1);
                    chk("first_at_16", 32'(slot_first), 32'd1);
                end
                19: chk("pix_at_19", 32'(pixel_en), 32'd1);
                20: begin
                    chk("first_at_20", 32'(slot_first), 32'd1);
                    chk("slot_at_20", 32'(slot), 32'd1);
                end
                24: chk("first_at_24", 32'(slot_first), 32'd1);
                28: chk("first_at_28", 32'(slot_first), 32'd1);
                31: chk("fe_at_31", 32'(frame_end), 32'd1);
                36: chk("slot1_even_frame", 32'(slot_valid), 32'd0);
                40: chk("slot2_even_frame", 32'(slot_valid), 32'd1);
                143: chk("en_at_143", 32'(sys_enable), 32'd1);
                144: begin
                    chk("en_at_144", 32'(sys_enable), 32'd0);
                    chk("refresh_at_144", 32'(refresh), 32'd1);
                end
                163: chk("pix_paused", 32'(pixel_en), 32'd0);
                165: begin
                    chk("io_paused", 32'(io_cycle), 32'd1);
                    chk("valid_paused", 32'(slot_valid), 32'd0);
                end
                default: ;
            endcase
            tick();
        end

        // act=5, tail=2: 22-cycle frames with two idle tail cycles.
        active_slots = 3'd5; tail_len = 2'd2; fast_mask = 5'b11111;
        repeat (300) begin
            #1;
            if (m_en && m_pos >= m_act * SUB) begin
                chk("tail_slot", 32'(slot), 32'd0);
                chk("tail_valid", 32'(slot_valid), 32'd0);
            end
            tick();
        end

        // reset_req and act change mid-frame.
        active_slots = 3'd4; tail_len = 2'd0;
        for (int i = 0; i < 60; i++) begin
            if (m_act == 4 && m_pos == 5) break;
            tick();
        end
        reset_req = 1'b1; active_slots = 3'd2;
        repeat (40) tick();
        reset_req = 1'b0;

        // DMA request held over several frames.
        active_slots = 3'd5; tail_len = 2'd1; dma_req = 1'b1;
        repeat (80) tick();
        dma_req = 1'b0;

        // Randomized inputs, occasional resets.
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) begin
                active_slots = 3'($urandom_range(0, 7));
                tail_len     = 2'($urandom_range(0, 3));
                fast_mask    = 5'($urandom);
            end
            pause     = ($urandom_range(0, 4) == 0);
            reset_req = ($urandom_range(0, 1) == 1);
            dma_req   = ($urandom_range(0, 1) == 1);
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
